// File: rtl/rtc_pkg.sv
// Shared RTC definitions: date layout, reset date, month constants, BCD helper.
package rtc_pkg;

  localparam int unsigned DATE_DAY_LSB  = 0;
  localparam int unsigned DATE_MON_LSB  = 8;
  localparam int unsigned DATE_YEAR_LSB = 16;

  localparam logic [31:0] RESET_DATE = 32'h2000_0101;

  localparam logic [7:0] MON_FEB = 8'h02;
  localparam logic [7:0] MON_DEC = 8'h12;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
  } bcd_date_t;

  // Two-digit BCD increment; result is {carry_out, tens, units}.
  // A units or tens nibble at 9 or above rolls to 0, so stray A-F values
  // still resolve deterministically instead of counting through hex.
  function automatic logic [8:0] bcd_inc2(input logic [7:0] v);
    logic [3:0] units;
    logic [3:0] tens;
    logic       carry;
    units = v[3:0];
    tens  = v[7:4];
    carry = 1'b0;
    if (units >= 4'd9) begin
      units = 4'd0;
      if (tens >= 4'd9) begin
        tens  = 4'd0;
        carry = 1'b1;
      end else begin
        tens = tens + 4'd1;
      end
    end else begin
      units = units + 4'd1;
    end
    return {carry, tens, units};
  endfunction

endpackage

// File: rtl/rtc_days_in_month.sv
// Combinational last-day-of-month lookup with Gregorian leap-year decode.
module rtc_days_in_month
  import rtc_pkg::*;
(
  input  logic [7:0]  month_i,
  input  logic [15:0] year_i,
  output logic [7:0]  last_day_o,
  output logic        leap_o
);

  // A two-digit BCD value is a multiple of 4 when an even tens digit pairs
  // with units 0/4/8, or an odd tens digit pairs with units 2/6.
  function automatic logic bcd_div4(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = v[7:4];
    u = v[3:0];
    return (!t[0] && (u == 4'd0 || u == 4'd4 || u == 4'd8)) ||
           ( t[0] && (u == 4'd2 || u == 4'd6));
  endfunction

  logic [7:0] yy;
  logic [7:0] cc;

  assign yy = year_i[7:0];
  assign cc = year_i[15:8];

  // Century years only leap when the century number is a multiple of 4.
  always_comb begin
    leap_o = (yy != 8'h00) ? bcd_div4(yy) : bcd_div4(cc);
  end

  // Month length table; unrecognised month codes fall back to 31 days.
  always_comb begin
    last_day_o = 8'h31;
    case (month_i)
      8'h04, 8'h06, 8'h09, 8'h11: last_day_o = 8'h30;
      MON_FEB:                    last_day_o = leap_o ? 8'h29 : 8'h28;
      default:                    last_day_o = 8'h31;
    endcase
  end

endmodule

// File: rtl/rtc_date.sv
// BCD calendar register advanced by the clock's day-rollover pulse.
module rtc_date
  import rtc_pkg::*;
#(
  parameter logic [31:0] RESET_DATE = rtc_pkg::RESET_DATE
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        new_day_i,
  input  logic        date_update_i,
  input  logic [31:0] date_i,
  output logic [31:0] date_o,
  output logic        leap_year_o,
  output logic        month_end_o
);

  logic [31:0] date_q;
  logic [31:0] date_d;
  logic        month_end_q;
  logic        month_end_d;

  bcd_date_t   cur;
  logic [7:0]  last_day;
  logic [8:0]  day_inc;
  logic [8:0]  mon_inc;
  logic [8:0]  yr_lo_inc;
  logic [8:0]  yr_hi_inc;
  logic        unused_carries;

  assign cur.day   = date_q[DATE_DAY_LSB  +: 8];
  assign cur.month = date_q[DATE_MON_LSB  +: 8];
  assign cur.year  = date_q[DATE_YEAR_LSB +: 16];

  rtc_days_in_month u_dim (
    .month_i    (cur.month),
    .year_i     (cur.year),
    .last_day_o (last_day),
    .leap_o     (leap_year_o)
  );

  assign day_inc   = bcd_inc2(cur.day);
  assign mon_inc   = bcd_inc2(cur.month);
  assign yr_lo_inc = bcd_inc2(cur.year[7:0]);
  assign yr_hi_inc = bcd_inc2(cur.year[15:8]);

  // Only the low year pair's carry matters; the rest wrap silently (9999 -> 0000).
  assign unused_carries = &{day_inc[8], mon_inc[8], yr_hi_inc[8]};

  // Next date: software load beats increment; increment ripples day -> month -> year.
  always_comb begin
    bcd_date_t nxt;
    nxt         = cur;
    month_end_d = 1'b0;
    if (date_update_i) begin
      nxt = bcd_date_t'(date_i);
    end else if (new_day_i) begin
      if (cur.day >= last_day) begin
        nxt.day     = 8'h01;
        month_end_d = 1'b1;
        if (cur.month < MON_DEC) begin
          nxt.month = mon_inc[7:0];
        end else begin
          nxt.month      = 8'h01;
          nxt.year[7:0]  = yr_lo_inc[7:0];
          nxt.year[15:8] = yr_lo_inc[8] ? yr_hi_inc[7:0] : cur.year[15:8];
        end
      end else begin
        nxt.day = day_inc[7:0];
      end
    end
    date_d = nxt;
  end

  // Date and month-end registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      date_q      <= RESET_DATE;
      month_end_q <= 1'b0;
    end else begin
      date_q      <= date_d;
      month_end_q <= month_end_d;
    end
  end

  assign date_o      = date_q;
  assign month_end_o = month_end_q;

endmodule

// File: tb/tb_rtc_date.sv
// Self-checking bench for rtc_date: directed calendar cases plus random traffic
// checked every cycle against an integer-arithmetic calendar model.
module tb_rtc_date;

  logic        clk = 1'b0;
  logic        rstn;
  logic        new_day;
  logic        date_update;
  logic [31:0] date_in;
  logic [31:0] date_out;
  logic        leap_year;
  logic        month_end;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_date;
  logic        exp_me;
  logic        model_valid = 1'b0;

  always #5 clk = ~clk;

  rtc_date #(.RESET_DATE(32'h2000_0101)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .new_day_i     (new_day),
    .date_update_i (date_update),
    .date_i        (date_in),
    .date_o        (date_out),
    .leap_year_o   (leap_year),
    .month_end_o   (month_end)
  );

  // ---------------- behavioural calendar model (plain integers) ----------------
  function automatic int bcd_to_int(input logic [15:0] v);
    return 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int_to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic is_leap(input int y);
    if (y % 100 != 0) return (y % 4) == 0;
    return ((y / 100) % 4) == 0;
  endfunction

  function automatic int month_len(input int m, input int y);
    case (m)
      4, 6, 9, 11: return 30;
      2:           return is_leap(y) ? 29 : 28;
      default:     return 31;
    endcase
  endfunction

  // Returns {month_end, next_date} after one day advance.
  function automatic logic [32:0] advance(input logic [31:0] dt);
    int y;
    int m;
    int d;
    logic me;
    y  = bcd_to_int(dt[31:16]);
    m  = bcd_to_int({8'h00, dt[15:8]});
    d  = bcd_to_int({8'h00, dt[7:0]});
    me = 1'b0;
    if (d >= month_len(m, y)) begin
      d  = 1;
      me = 1'b1;
      if (m < 12) m = m + 1;
      else begin
        m = 1;
        y = (y + 1) % 10000;
      end
    end else begin
      d = d + 1;
    end
    return {me, int_to_bcd(y), int_to_bcd(m)[7:0], int_to_bcd(d)[7:0]};
  endfunction

  // Model state follows the same inputs the DUT sees at each rising edge.
  always @(posedge clk) begin
    if (!rstn) begin
      exp_date    <= 32'h2000_0101;
      exp_me      <= 1'b0;
      model_valid <= 1'b1;
    end else if (date_update) begin
      exp_date <= date_in;
      exp_me   <= 1'b0;
    end else if (new_day) begin
      exp_date <= advance(exp_date)[31:0];
      exp_me   <= advance(exp_date)[32];
    end else begin
      exp_me   <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      checks = checks + 3;
      if (date_out !== exp_date) begin
        errors = errors + 1;
        $display("FAIL model_date t=%0t got=%h exp=%h", $time, date_out, exp_date);
      end
      if (leap_year !== is_leap(bcd_to_int(exp_date[31:16]))) begin
        errors = errors + 1;
        $display("FAIL model_leap t=%0t date=%h got=%b exp=%b", $time, date_out, leap_year,
                 is_leap(bcd_to_int(exp_date[31:16])));
      end
      if (month_end !== exp_me) begin
        errors = errors + 1;
        $display("FAIL model_month_end t=%0t date=%h got=%b exp=%b", $time, date_out, month_end, exp_me);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Apply inputs for one clock; returns 1 time unit after the capturing edge.
  task automatic drive(input logic r, input logic u, input logic n, input logic [31:0] d);
    rstn        = r;
    date_update = u;
    new_day     = n;
    date_in     = d;
    @(posedge clk);
    #1;
    $display("txn rstn=%b load=%b new_day=%b date_i=%h -> date_o=%h leap=%b month_end=%b",
             r, u, n, d, date_out, leap_year, month_end);
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic load_pulse(input logic [31:0] d);
    drive(1'b1, 1'b1, 1'b0, d);
    drive(1'b1, 1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    rstn = 1'b0; date_update = 1'b0; new_day = 1'b0; date_in = 32'h0;

    // Reset
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk32("reset_date", date_out, 32'h2000_0101);
    chk1("reset_leap", leap_year, 1'b1);
    chk1("reset_month_end", month_end, 1'b0);

    // Leap February
    load_pulse(32'h2024_0228);
    chk32("leap_feb_29", date_out, 32'h2024_0229);
    chk1("leap_feb_29_me", month_end, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h0);
    chk32("leap_mar_01", date_out, 32'h2024_0301);
    chk1("leap_mar_01_me", month_end, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk1("month_end_single", month_end, 1'b0);

    // Century rule
    load_pulse(32'h1900_0228);
    chk32("century_1900", date_out, 32'h1900_0301);
    chk1("century_1900_leap", leap_year, 1'b0);
    load_pulse(32'h2000_0228);
    chk32("century_2000", date_out, 32'h2000_0229);
    chk1("century_2000_leap", leap_year, 1'b1);

    // Year and BCD wrap
    load_pulse(32'h9999_1231);
    chk32("year_wrap", date_out, 32'h0000_0101);
    chk1("year_wrap_me", month_end, 1'b1);
    load_pulse(32'h2019_0909);
    chk32("bcd_day_wrap", date_out, 32'h2019_0910);
    load_pulse(32'h2019_0930);
    chk32("bcd_month_wrap", date_out, 32'h2019_1001);
    load_pulse(32'h2099_1231);
    chk32("bcd_year_digit", date_out, 32'h2100_0101);
    chk1("year_2100_leap", leap_year, 1'b0);

    // Collision and reset mid-stream
    drive(1'b1, 1'b1, 1'b1, 32'h2030_0615);
    chk32("collision", date_out, 32'h2030_0615);
    chk1("collision_me", month_end, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    chk32("reset_mid", date_out, 32'h2000_0101);
    chk1("reset_mid_me", month_end, 1'b0);

    // Invalid day recovery
    load_pulse(32'h2023_0431);
    chk32("invalid_day", date_out, 32'h2023_0501);
    chk1("invalid_day_me", month_end, 1'b1);

    // Back-to-back pulses across a year boundary
    drive(1'b1, 1'b1, 1'b0, 32'h2023_1230);
    drive(1'b1, 1'b0, 1'b1, 32'h0);
    chk32("b2b_1", date_out, 32'h2023_1231);
    drive(1'b1, 1'b0, 1'b1, 32'h0);
    chk32("b2b_2", date_out, 32'h2024_0101);
    drive(1'b1, 1'b0, 1'b1, 32'h0);
    chk32("b2b_3", date_out, 32'h2024_0102);

    // Random traffic checked by the model on every cycle
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic       u;
      logic       n;
      logic [31:0] d;
      int y;
      int m;
      int dd;
      r = ($urandom_range(0, 99) != 0);
      u = ($urandom_range(0, 15) == 0);
      n = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       y = $urandom_range(0, 9999);
        1:       y = 100 * $urandom_range(0, 99);
        2:       y = 9999;
        default: y = 4 * $urandom_range(0, 2499);
      endcase
      m  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 12);
      dd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 39) : $urandom_range(26, 31);
      d  = {int_to_bcd(y), int_to_bcd(m)[7:0], int_to_bcd(dd)[7:0]};
      drive(r, u, n, d);
    end

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtc_date.md
# rtc_date

Calendar counter that consumes the `update_day_o` pulse of `rtc_clock` and maintains a BCD date (year/month/day) with full Gregorian leap-year handling. It is the receiving end of the clock-to-calendar day-rollover interface. It sits beside `rtc_clock` in the RTC subsystem, and its date word is exposed to the register interface for read-back and software load.

## Interface

Parameters:
- `RESET_DATE`, default `32'h2000_0101`: BCD date loaded at reset, encoded as {YYYY, MM, DD}.

Ports:
- `clk_i` in 1: single clock.
- `rstn_i` in 1: reset, synchronous, active-low.
- `new_day_i` in 1: one-cycle day-advance pulse, driven by `rtc_clock.update_day_o`.
- `date_update_i` in 1: one-cycle software load strobe.
- `date_i` in 32: BCD date to load.
  - [31:16] is YYYY.
  - [15:8] is MM.
  - [7:0] is DD.
- `date_o` out 32: current BCD date, same encoding as `date_i`, registered.
- `leap_year_o` out 1: current year (`date_o[31:16]`) is a leap year. Combinational from `date_o`.
- `month_end_o` out 1: one-cycle registered pulse, asserted in the cycle after a day increment that wrapped the month.

## Operation

- Reset (`rstn_i` low at a `clk_i` edge):
  - `date_o` = `RESET_DATE`.
  - `month_end_o` = 0.
  - Reset overrides every other input, including mid-increment.
- Load: when `date_update_i` = 1, `date_o` takes the value of `date_i` at the next edge.
  - The value is taken verbatim; no validity check is made.
  - `month_end_o` = 0 on a load.
  - If `new_day_i` is high in the same cycle, the load wins and the increment is discarded.
- Increment (`new_day_i` = 1, no load) is a BCD carry chain:
  - DD < last(MM,YYYY): DD = DD+1 in BCD (09 goes to 10, 19 to 20, 29 to 30).
  - DD >= last: DD = 01, month carry, `month_end_o` = 1 next cycle.
  - On month carry with MM < 12: MM = MM+1 in BCD (09 goes to 10).
  - On month carry with MM >= 12: MM = 01 and year carry.
  - Year carry: YYYY = YYYY+1 as 4-digit BCD; 9999 wraps to 0000.
- last(MM,YYYY):
  - 31 for months 01, 03, 05, 07, 08, 10, 12.
  - 30 for months 04, 06, 09, 11.
  - February: 29 if leap, else 28.
  - Any other MM value (invalid): 31.
  - The `>=` comparison on DD guarantees that out-of-range loaded days recover on the next increment.
- Leap rule:
  - YY (lower two digits) != 00: leap iff YY divisible by 4.
  - YY == 00: leap iff CC (upper two digits) divisible by 4.
- BCD divisibility by 4 for a two-digit value {t,u}:
  - t even and u in {0,4,8}; or
  - t odd and u in {2,6}.
- Non-BCD nibbles (A to F) loaded by software: behaviour is only required to be deterministic and to never hang. No correction is mandated.

## Timing

- Latency: `date_o` reflects a load or increment exactly 1 cycle after the input strobe.
- `leap_year_o` follows `date_o` with 0 cycles of latency.
- `month_end_o` is high for exactly one cycle, aligned with the updated `date_o`.
- Back-to-back `new_day_i` pulses on consecutive cycles each advance the date by one day; no pulse is dropped.
- No handshake and no busy state: one update per cycle.
- `new_day_i` held high advances the date by one day per cycle.
- No state machine beyond the date register. All next-state logic completes in a single cycle.

## Structure

- Package `rtc_pkg`, shared with `rtc_clock`, holds:
  - date field offsets: `DATE_DAY_LSB` = 0, `DATE_MON_LSB` = 8, `DATE_YEAR_LSB` = 16;
  - the `RESET_DATE` default constant;
  - a `bcd_date_t` packed struct {year[15:0], month[7:0], day[7:0]};
  - month constants `MON_FEB` = 8'h02 and `MON_DEC` = 8'h12.
- Sub-module `rtc_days_in_month` is combinational:
  - inputs: month[7:0], year[15:0];
  - outputs: last_day[7:0] (BCD), leap.
  - The leap decode lives here and drives `leap_year_o`.
- The BCD increment is a package function `bcd_inc2`, a two-digit increment with carry-out. YYYY uses two chained instances.

## Test plan

- Reset:
  - Stimulus: `rstn_i` low for 2 cycles, then high, no strobes.
  - Required: `date_o` = 0x2000_0101, `leap_year_o` = 1, `month_end_o` = 0.
- Leap February:
  - Stimulus: load 0x2024_0228, then 2 `new_day_i` pulses.
  - Required: `date_o` goes 0x2024_0229, then 0x2024_0301; `month_end_o` pulses on the second update only.
- Century rule:
  - Stimulus: load 0x1900_0228 and pulse.
  - Required: 0x1900_0301, `leap_year_o` = 0.
  - Stimulus: load 0x2000_0228 and pulse.
  - Required: 0x2000_0229.
- Year and BCD wrap:
  - Stimulus: load 0x9999_1231 and pulse.
  - Required: 0x0000_0101, `month_end_o` = 1.
  - Stimulus: load 0x2019_0909 and pulse.
  - Required: 0x2019_0910.
- Collision and reset mid-stream:
  - Stimulus: `date_update_i` and `new_day_i` together with `date_i` = 0x2030_0615.
  - Required: `date_o` = 0x2030_0615.
  - Stimulus: `rstn_i` low during a `new_day_i` pulse.
  - Required: `date_o` = `RESET_DATE`.
- Invalid day recovery:
  - Stimulus: load 0x2023_0431 and pulse.
  - Required: 0x2023_0501, `month_end_o` = 1.
